serial_bit_source: RTL and testbench

Parallel-to-serial stage that feeds the 1011 sequence detector's `din` input. It accepts WIDTH-bit words through a valid/ready handshake and emits them one bit per advance step on a registered serial output. A one-word holding register lets words stream back-to-back with no idle bit between them. `dout` connects directly to the detector's `din`, and the detector samples it every clock.

---
 rtl/serial_bit_source_if.sv | 23 ++
 rtl/serial_bit_source.sv | 116 +++++++++++
 tb/tb_serial_bit_source.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_bit_source_if.sv
// Word-in / bit-out bus between a word source and the serial_bit_source shifter.
interface serial_bit_source_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             bit_en;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             word_done;

  modport master (
    output in_valid, in_data, bit_en,
    input  in_ready, dout, dout_valid, busy, word_done
  );

  modport slave (
    input  in_valid, in_data, bit_en,
    output in_ready, dout, dout_valid, busy, word_done
  );
endinterface

// File: rtl/serial_bit_source.sv
// Parallel-to-serial stage with a one-word holding register so that words
// stream back-to-back onto the 1011 detector input with no gap bit.
module serial_bit_source #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_bit_source_if.slave  bus
);

  localparam int unsigned    CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam logic [0:0]     S_IDLE  = 1'b0;
  localparam logic [0:0]     S_SHIFT = 1'b1;

  logic [0:0]       r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_hold,       w_hold_nxt;
  logic             r_hold_valid, w_hold_valid_nxt;
  logic [WIDTH-1:0] r_sh,         w_sh_nxt;
  logic [CW-1:0]    r_cnt,        w_cnt_nxt;
  logic             r_dout,       w_dout_nxt;
  logic             r_dout_valid, w_dout_valid_nxt;
  logic             r_word_done,  w_word_done_nxt;
  logic [WIDTH-1:0] w_shifted;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign w_shifted = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_sh         <= '0;
      r_cnt        <= '0;
      r_dout       <= IDLE_BIT;
      r_dout_valid <= 1'b0;
      r_word_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_sh         <= w_sh_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_word_done  <= w_word_done_nxt;
    end
  end

  // Next state: accept into hold, load hold into the shifter, advance bits
  always_comb begin
    w_state_nxt      = r_state;
    w_hold_nxt       = r_hold;
    w_hold_valid_nxt = r_hold_valid;
    w_sh_nxt         = r_sh;
    w_cnt_nxt        = r_cnt;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = r_dout_valid;
    w_word_done_nxt  = 1'b0;

    // Accept needs an empty hold, load needs a full one: never both on one edge
    if (bus.in_valid && !r_hold_valid) begin
      w_hold_nxt       = bus.in_data;
      w_hold_valid_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (r_hold_valid) begin
          w_sh_nxt         = r_hold;
          w_hold_valid_nxt = 1'b0;
          w_cnt_nxt        = '0;
          w_dout_nxt       = first_bit(r_hold);
          w_dout_valid_nxt = 1'b1;
          w_state_nxt      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.bit_en) begin
          if (r_cnt == LAST) begin
            w_word_done_nxt = 1'b1;
            if (r_hold_valid) begin
              w_sh_nxt         = r_hold;
              w_hold_valid_nxt = 1'b0;
              w_cnt_nxt        = '0;
              w_dout_nxt       = first_bit(r_hold);
            end else begin
              w_dout_nxt       = IDLE_BIT;
              w_dout_valid_nxt = 1'b0;
              w_state_nxt      = S_IDLE;
            end
          end else begin
            w_sh_nxt   = w_shifted;
            w_cnt_nxt  = r_cnt + CW'(1);
            w_dout_nxt = first_bit(w_shifted);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready   = !r_hold_valid;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.word_done  = r_word_done;
  assign bus.busy       = (r_state == S_SHIFT) || r_hold_valid;

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: vector table for WIDTH=4 MSB-first,
// plus hand-written reset, LSB-first and mid-word reset sequences.
module tb_serial_bit_source;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_bit_source_if #(.WIDTH(4)) if4 ();
  serial_bit_source_if #(.WIDTH(8)) if8 ();

  serial_bit_source #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave));
  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave));

  int n_total = 0;
  int n_pass  = 0;

  // Reference 1011 detector watching the WIDTH=4 serial stream
  logic [3:0] r_hist = 4'b0;
  int det_cnt = 0;
  always @(posedge clk) begin
    r_hist <= {r_hist[2:0], if4.dout};
    if ({r_hist[2:0], if4.dout} == 4'b1011) det_cnt <= det_cnt + 1;
  end

  typedef struct {
    logic       iv;
    logic [3:0] d;
    logic       en;
    logic       rdy;
    logic       dout;
    logic       dv;
    logic       wd;
    logic       busy;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input int idx, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %b want %b", nm, idx, act, exp);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic add(input logic iv, input logic [3:0] d, input logic en,
                     input logic rdy, input logic dout, input logic dv,
                     input logic wd, input logic busy);
    vec_t v;
    v.iv = iv; v.d = d; v.en = en;
    v.rdy = rdy; v.dout = dout; v.dv = dv; v.wd = wd; v.busy = busy;
    vq.push_back(v);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if4.in_valid = vq[i].iv;
      if4.in_data  = vq[i].d;
      if4.bit_en   = vq[i].en;
      @(posedge clk); #1;
      chk("rdy",  i, if4.in_ready,   vq[i].rdy);
      chk("dout", i, if4.dout,       vq[i].dout);
      chk("dv",   i, if4.dout_valid, vq[i].dv);
      chk("wd",   i, if4.word_done,  vq[i].wd);
      chk("busy", i, if4.busy,       vq[i].busy);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  int seg0, seg1, seg2, seg3;
  int det0;
  logic [7:0] lsb_word;

  initial begin
    // Single word 1011, bit_en=1
    seg0 = vq.size();
    add(1, 4'b1011, 1, 0, 0, 0, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 0, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 0, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 0, 0, 0, 0);
    // Back-to-back 1011, 0100, 1011
    seg1 = vq.size();
    add(1, 4'b1011, 1, 0, 0, 0, 0, 1);
    add(1, 4'b0100, 1, 1, 1, 1, 0, 1);
    add(1, 4'b0100, 1, 0, 0, 1, 0, 1);
    add(1, 4'b1011, 1, 0, 1, 1, 0, 1);
    add(1, 4'b1011, 1, 0, 1, 1, 0, 1);
    add(1, 4'b1011, 1, 1, 0, 1, 1, 1);
    add(1, 4'b1011, 1, 0, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 0, 0, 1, 0, 1);
    add(0, 4'b0000, 1, 0, 0, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 1, 1, 1);
    add(0, 4'b0000, 1, 1, 0, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 0, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 0, 0, 0, 0);
    // bit_en every third cycle; in_data changes to 1111 while stalled
    seg2 = vq.size();
    add(1, 4'b1011, 0, 0, 0, 0, 0, 1);
    add(1, 4'b0110, 0, 1, 1, 1, 0, 1);
    add(1, 4'b0110, 1, 0, 0, 1, 0, 1);
    add(1, 4'b1111, 0, 0, 0, 1, 0, 1);
    add(1, 4'b1111, 0, 0, 0, 1, 0, 1);
    add(1, 4'b1111, 1, 0, 1, 1, 0, 1);
    add(1, 4'b1111, 0, 0, 1, 1, 0, 1);
    add(1, 4'b1111, 0, 0, 1, 1, 0, 1);
    add(1, 4'b1111, 1, 0, 1, 1, 0, 1);
    add(1, 4'b1111, 0, 0, 1, 1, 0, 1);
    add(0, 4'b1111, 0, 0, 1, 1, 0, 1);
    add(0, 4'b1111, 1, 1, 0, 1, 1, 1);
    add(0, 4'b0000, 0, 1, 0, 1, 0, 1);
    add(0, 4'b0000, 0, 1, 0, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 0, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 0, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 0, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 0, 1, 1, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 0, 1, 0, 1);
    add(0, 4'b0000, 0, 1, 0, 1, 0, 1);
    add(0, 4'b0000, 0, 1, 0, 1, 0, 1);
    add(0, 4'b0000, 1, 1, 0, 0, 1, 0);
    add(0, 4'b0000, 0, 1, 0, 0, 0, 0);
    seg3 = vq.size();

    // Reset held with in_valid=1: nothing may be accepted
    if4.in_valid = 1'b1; if4.in_data = 4'b1011; if4.bit_en = 1'b1;
    if8.in_valid = 1'b0; if8.in_data = 8'h00;   if8.bit_en = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_rdy",  0, if4.in_ready,   1'b1);
    chk("rst_dout", 0, if4.dout,       1'b0);
    chk("rst_dv",   0, if4.dout_valid, 1'b0);
    chk("rst_busy", 0, if4.busy,       1'b0);
    chk("rst_wd",   0, if4.word_done,  1'b0);
    chk("rst_dv8",  0, if8.dout_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_busy", 0, if4.busy,     1'b0);
    chk("rel_rdy",  0, if4.in_ready, 1'b1);

    det0 = det_cnt;
    run_rows(seg0, seg1);
    chk_int("det_single", det_cnt - det0, 1);
    det0 = det_cnt;
    run_rows(seg1, seg2);
    chk_int("det_b2b", det_cnt - det0, 2);
    run_rows(seg2, seg3);

    // LSB-first, WIDTH=8, 8'hB4 -> 0,0,1,0,1,1,0,1
    lsb_word = 8'hB4;
    if8.in_valid = 1'b1; if8.in_data = lsb_word;
    tick();
    chk("lsb_rdy", 0, if8.in_ready, 1'b0);
    if8.in_valid = 1'b0; if8.in_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("lsb_dout", k, if8.dout,       lsb_word[k]);
      chk("lsb_dv",   k, if8.dout_valid, 1'b1);
    end
    tick();
    chk("lsb_end_dv", 0, if8.dout_valid, 1'b0);
    chk("lsb_end_wd", 0, if8.word_done,  1'b1);

    // Mid-word reset with a second word held
    if4.bit_en = 1'b1;
    if4.in_valid = 1'b1; if4.in_data = 4'b1011;
    tick();
    if4.in_data = 4'b0100;
    tick();
    tick();
    chk("mw_dout2", 0, if4.dout,     1'b0);
    chk("mw_rdy",   0, if4.in_ready, 1'b0);
    if4.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mw_rdy",  1, if4.in_ready,   1'b1);
    chk("mw_dout", 1, if4.dout,       1'b0);
    chk("mw_dv",   1, if4.dout_valid, 1'b0);
    chk("mw_busy", 1, if4.busy,       1'b0);
    chk("mw_wd",   1, if4.word_done,  1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_dout", k, if4.dout,       1'b0);
      chk("post_dv",   k, if4.dout_valid, 1'b0);
      chk("post_busy", k, if4.busy,       1'b0);
    end
    if4.in_valid = 1'b1; if4.in_data = 4'b1000;
    tick();
    if4.in_valid = 1'b0;
    tick();
    chk("new_dout", 0, if4.dout,       1'b1);
    chk("new_dv",   0, if4.dout_valid, 1'b1);
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
